// File: rtl/sdram_pkg.sv
// Shared SDRAM helpers: the drain/fill FSM state encoding, the default burst
// length and a small length-clamp helper used when a partial burst is issued.
package sdram_pkg;

  // Common burst FSM encoding, shared by the write drain and the read filler.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_WAIT = 2'd3
  } sdram_state_e;

  // Default full burst length in words.
  localparam int unsigned SDRAM_BURST_LEN = 8;

  // Width of the burst length field on the controller command interface.
  localparam int unsigned SDRAM_LEN_WIDTH = 8;

  // Clamp a FIFO fill level to the burst length cap: min(level, cap).
  function automatic logic [7:0] sdram_min_len(input logic [31:0] level,
                                               input logic [7:0]  cap);
    if (level < {24'd0, cap}) begin
      return level[7:0];
    end else begin
      return cap;
    end
  endfunction

endpackage

// File: rtl/sdram_addr_wrap.sv
// Next burst address: advance by the burst length, or restart at the buffer
// base once the end of the burst would pass the last buffer address.
module sdram_addr_wrap #(
  parameter int unsigned                ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0]      ADDR_BASE  = '0,
  parameter logic [ADDR_WIDTH-1:0]      ADDR_TOP   = '1
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  output logic [ADDR_WIDTH-1:0] o_next
);

  // One extra bit so an advance past the top of the address space is visible.
  logic [ADDR_WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_addr} + (ADDR_WIDTH+1)'(i_len);

  // Wrap to the base when the advanced address runs off the end of the buffer.
  always_comb begin
    if (w_sum > {1'b0, ADDR_TOP}) begin
      o_next = ADDR_BASE;
    end else begin
      o_next = w_sum[ADDR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sdram_wr_drain.sv
// Write-side SDRAM drain: pulls words from a show-ahead FIFO and hands them to
// an SDRAM controller as write bursts. Full bursts start as soon as enough data
// is buffered; with flush held, whatever is buffered goes out as a short burst.
module sdram_wr_drain
  import sdram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           DEPTH_WIDTH = 10,
  parameter int unsigned           ADDR_WIDTH  = 24,
  parameter int unsigned           BURST_LEN   = SDRAM_BURST_LEN,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE   = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_TOP    = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   addr_load,
  input  logic [ADDR_WIDTH-1:0]  addr_in,
  output logic                   fifo_rd_req,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic [DEPTH_WIDTH-1:0] fifo_rd_num,
  input  logic                   fifo_rd_empty,
  output logic                   burst_req,
  input  logic                   burst_ack,
  output logic [ADDR_WIDTH-1:0]  burst_addr,
  output logic [7:0]             burst_len,
  input  logic                   wr_data_req,
  output logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   burst_done,
  output logic                   busy,
  output logic                   underflow,
  output logic [15:0]            burst_cnt
);

  localparam logic [7:0] LP_BURST_LEN = 8'(BURST_LEN);

  sdram_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_beats;
  logic [15:0]           r_cnt;
  logic                  r_underflow;
  logic                  r_burst_req;
  logic                  r_busy;

  logic                  w_full;
  logic                  w_partial;
  logic [7:0]            w_partial_len;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_rd_req;

  assign w_full        = (32'(fifo_rd_num) >= 32'(BURST_LEN));
  assign w_partial     = flush & ~fifo_rd_empty;
  assign w_partial_len = sdram_min_len(32'(fifo_rd_num), LP_BURST_LEN);

  sdram_addr_wrap #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_BASE  (ADDR_BASE),
    .ADDR_TOP   (ADDR_TOP)
  ) u_addr_wrap (
    .i_addr (r_addr),
    .i_len  (r_len),
    .o_next (w_next_addr)
  );

  // Pop the FIFO only while streaming a burst and only when a word is there.
  always_comb begin
    if (r_state == ST_DATA) begin
      w_rd_req = wr_data_req & ~fifo_rd_empty;
    end else begin
      w_rd_req = 1'b0;
    end
  end

  // Burst sequencing: start, command handshake, data beats, completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= ADDR_BASE;
      r_len       <= 8'd0;
      r_beats     <= 8'd0;
      r_cnt       <= 16'd0;
      r_underflow <= 1'b0;
      r_burst_req <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (addr_load) begin
            // A new start address wins; any burst start waits a cycle.
            r_addr <= addr_in;
          end else if (enable && w_full) begin
            r_len       <= LP_BURST_LEN;
            r_burst_req <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_REQ;
          end else if (enable && w_partial) begin
            r_len       <= w_partial_len;
            r_burst_req <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_REQ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (burst_ack) begin
            r_beats     <= r_len;
            r_burst_req <= 1'b0;
            r_state     <= ST_DATA;
          end else begin
            r_state <= ST_REQ;
          end
        end
        ST_DATA: begin
          if (wr_data_req) begin
            // The controller has taken the beat whether or not data was there.
            r_beats <= r_beats - 8'd1;
            if (fifo_rd_empty) begin
              r_underflow <= 1'b1;
            end
            if (r_beats == 8'd1) begin
              r_state <= ST_WAIT;
            end
          end else begin
            r_state <= ST_DATA;
          end
        end
        ST_WAIT: begin
          if (burst_done) begin
            r_cnt   <= r_cnt + 16'd1;
            r_addr  <= w_next_addr;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        default: begin
          r_burst_req <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_req = w_rd_req;
  assign wr_data     = fifo_rd_data;
  assign burst_req   = r_burst_req;
  assign burst_addr  = r_addr;
  assign burst_len   = r_len;
  assign busy        = r_busy;
  assign underflow   = r_underflow;
  assign burst_cnt   = r_cnt;

endmodule

// File: tb/tb_sdram_wr_drain.sv
// Directed bench for sdram_wr_drain with a small show-ahead FIFO model.
`timescale 1ns/1ps
module tb_sdram_wr_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush;
  logic        addr_load;
  logic [23:0] addr_in;
  logic        fifo_rd_req;
  logic [15:0] fifo_rd_data;
  logic [9:0]  fifo_rd_num;
  logic        fifo_rd_empty;
  logic        burst_req;
  logic        burst_ack;
  logic [23:0] burst_addr;
  logic [7:0]  burst_len;
  logic        wr_data_req;
  logic [15:0] wr_data;
  logic        burst_done;
  logic        busy;
  logic        underflow;
  logic [15:0] burst_cnt;

  int checks = 0;
  int errors = 0;

  // FIFO model
  logic [15:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        empty_force = 1'b0;

  assign fifo_rd_data  = mem[rd_ptr[5:0]];
  assign fifo_rd_num   = 10'(wr_ptr - rd_ptr);
  assign fifo_rd_empty = (wr_ptr == rd_ptr) | empty_force;

  always #5 clk = ~clk;

  // FIFO pop
  always @(posedge clk) begin
    if (fifo_rd_req) rd_ptr <= rd_ptr + 1;
  end

  sdram_wr_drain #(.ADDR_TOP(24'd15)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .flush         (flush),
    .addr_load     (addr_load),
    .addr_in       (addr_in),
    .fifo_rd_req   (fifo_rd_req),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_num   (fifo_rd_num),
    .fifo_rd_empty (fifo_rd_empty),
    .burst_req     (burst_req),
    .burst_ack     (burst_ack),
    .burst_addr    (burst_addr),
    .burst_len     (burst_len),
    .wr_data_req   (wr_data_req),
    .wr_data       (wr_data),
    .burst_done    (burst_done),
    .busy          (busy),
    .underflow     (underflow),
    .burst_cnt     (burst_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req"}, 32'(burst_req), 32'd0);
    chk({tag, "_rdreq"}, 32'(fifo_rd_req), 32'd0);
    chk({tag, "_addr"}, 32'(burst_addr), 32'd0);
    chk({tag, "_len"}, 32'(burst_len), 32'd0);
    chk({tag, "_cnt"}, 32'(burst_cnt), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; addr_load = 1'b0; addr_in = 24'd0;
    burst_ack = 1'b0; wr_data_req = 1'b0; burst_done = 1'b0;
    tick();
    chk_reset_outputs("rst");
    rst = 1'b0;

    // Full burst of 8 from address 0
    for (int i = 0; i < 8; i++) push(16'hA000 + 16'(i));
    enable = 1'b1;
    tick();
    chk("full_req", 32'(burst_req), 32'd1);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_addr", 32'(burst_addr), 32'd0);
    chk("full_len", 32'(burst_len), 32'd8);
    enable = 1'b0; burst_ack = 1'b1;
    tick();
    burst_ack = 1'b0;
    chk("full_req_drop", 32'(burst_req), 32'd0);
    for (int i = 0; i < 8; i++) begin
      wr_data_req = 1'b1;
      #1;
      chk("full_data", 32'(wr_data), 32'(16'hA000 + 16'(i)));
      chk("full_pop", 32'(fifo_rd_req), 32'd1);
      tick();
    end
    chk("full_pops", 32'(rd_ptr), 32'd8);
    // Still in WAIT: requests are ignored
    #1;
    chk("wait_rdreq", 32'(fifo_rd_req), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    wr_data_req = 1'b0;
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("full_cnt", 32'(burst_cnt), 32'd1);
    chk("full_next", 32'(burst_addr), 32'd8);
    chk("full_idle", 32'(busy), 32'd0);

    // Flush partial burst of 3 from address 0
    addr_load = 1'b1; addr_in = 24'd0;
    tick();
    addr_load = 1'b0;
    chk("load0", 32'(burst_addr), 32'd0);
    for (int i = 0; i < 3; i++) push(16'hB000 + 16'(i));
    flush = 1'b1; enable = 1'b1;
    tick();
    flush = 1'b0; enable = 1'b0;
    chk("flush_req", 32'(burst_req), 32'd1);
    chk("flush_len", 32'(burst_len), 32'd3);
    burst_ack = 1'b1;
    tick();
    burst_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data_req = 1'b1;
      #1;
      chk("flush_data", 32'(wr_data), 32'(16'hB000 + 16'(i)));
      tick();
    end
    wr_data_req = 1'b0;
    chk("flush_pops", 32'(rd_ptr), 32'd11);
    chk("flush_wait", 32'(busy), 32'd1);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("flush_next", 32'(burst_addr), 32'd3);
    chk("flush_cnt", 32'(burst_cnt), 32'd2);

    // Wrap: load 12 with a same-cycle start, stalled ack, enable dropped in DATA
    for (int i = 0; i < 8; i++) push(16'hC000 + 16'(i));
    addr_load = 1'b1; addr_in = 24'd12; enable = 1'b1;
    tick();
    addr_load = 1'b0;
    chk("load_prio_idle", 32'(busy), 32'd0);
    chk("load12", 32'(burst_addr), 32'd12);
    tick();
    chk("wrap_req", 32'(burst_req), 32'd1);
    burst_done = 1'b1; addr_load = 1'b1; addr_in = 24'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", 32'(burst_req), 32'd1);
      chk("stall_addr", 32'(burst_addr), 32'd12);
      chk("stall_len", 32'(burst_len), 32'd8);
    end
    burst_done = 1'b0; addr_load = 1'b0;
    burst_ack = 1'b1;
    tick();
    burst_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) enable = 1'b0;
      wr_data_req = 1'b1;
      #1;
      chk("wrap_data", 32'(wr_data), 32'(16'hC000 + 16'(i)));
      tick();
    end
    wr_data_req = 1'b0;
    chk("wrap_pops", 32'(rd_ptr), 32'd19);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("wrap_next", 32'(burst_addr), 32'd0);
    chk("wrap_cnt", 32'(burst_cnt), 32'd3);

    // Underflow: FIFO reports empty on beats 3 and 4
    for (int i = 0; i < 8; i++) push(16'hD000 + 16'(i));
    enable = 1'b1;
    tick();
    enable = 1'b0; burst_ack = 1'b1;
    tick();
    burst_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      empty_force = (i == 3 || i == 4);
      wr_data_req = 1'b1;
      #1;
      if (i == 3 || i == 4) begin
        chk("unf_nopop", 32'(fifo_rd_req), 32'd0);
      end else begin
        chk("unf_data", 32'(wr_data), 32'(16'hD000 + 16'(i < 3 ? i : i - 2)));
      end
      tick();
    end
    empty_force = 1'b0;
    wr_data_req = 1'b0;
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_wait", 32'(busy), 32'd1);
    chk("unf_pops", 32'(rd_ptr), 32'd25);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("unf_cnt", 32'(burst_cnt), 32'd4);
    chk("unf_next", 32'(burst_addr), 32'd8);
    chk("unf_sticky", 32'(underflow), 32'd1);

    // Reset in DATA after 4 beats
    for (int i = 0; i < 6; i++) push(16'hE000 + 16'(i));
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("rstb_addr", 32'(burst_addr), 32'd8);
    burst_ack = 1'b1;
    tick();
    burst_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_data_req = 1'b1;
      tick();
    end
    chk("rstb_pops", 32'(rd_ptr), 32'd29);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    tick();
    chk("arst_nopop", 32'(rd_ptr), 32'd29);
    rst = 1'b0; wr_data_req = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_wr_drain.md
SDRAM_WR_DRAIN -- requirements
Module: sdram_wr_drain

Interface
REQ-001 The block SHALL have a single clock, and its reset SHALL be asynchronous and active-high: clk input 1 (all state on posedge); rst input 1 (asynchronous, active-high).
REQ-002 Parameters SHALL be, as name, default, meaning:
- DATA_WIDTH, 16, data word width.
- DEPTH_WIDTH, 10, width of the FIFO fill-level input.
- ADDR_WIDTH, 24, SDRAM word address width.
- BURST_LEN, 8, full burst length in words (1..255).
- ADDR_BASE, 0, first buffer address.
- ADDR_TOP, 24'hFFFFFF, last buffer address.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk, input, 1, clock.
- rst, input, 1, reset.
- enable, input, 1, permit new bursts.
- flush, input, 1, level; permit a partial burst.
- addr_load, input, 1, load start address.
- addr_in, input, ADDR_WIDTH, start address.
- fifo_rd_req, output, 1, pop one FIFO word.
- fifo_rd_data, input, DATA_WIDTH, show-ahead FIFO head word.
- fifo_rd_num, input, DEPTH_WIDTH, FIFO fill level.
- fifo_rd_empty, input, 1, FIFO empty.
- burst_req, output, 1, write-burst command valid.
- burst_ack, input, 1, controller accepted command.
- burst_addr, output, ADDR_WIDTH, burst start address.
- burst_len, output, 8, burst length in words.
- wr_data_req, input, 1, controller consumes one word this cycle.
- wr_data, output, DATA_WIDTH, write data.
- burst_done, input, 1, controller finished burst.
- busy, output, 1, FSM not IDLE.
- underflow, output, 1, sticky error.
- burst_cnt, output, 16, completed bursts.

Function
REQ-004 FSM states SHALL be IDLE, REQ, DATA, WAIT.
REQ-005 IDLE->REQ SHALL occur when enable=1 and fifo_rd_num>=BURST_LEN, with burst_len latched as BURST_LEN.
REQ-006 Otherwise, IDLE->REQ SHALL occur when enable=1, flush=1 and fifo_rd_empty=0, with burst_len latched as min(fifo_rd_num, BURST_LEN).
REQ-007 In REQ, burst_req SHALL be 1; burst_addr and burst_len SHALL stay stable until burst_ack; burst_ack SHALL move REQ->DATA and load the beat counter with burst_len.
REQ-008 In DATA: fifo_rd_req = wr_data_req & ~fifo_rd_empty (combinational); wr_data = fifo_rd_data (combinational, zero latency); each wr_data_req decrements the beat counter.
REQ-009 The wr_data_req that brings the beat counter to 0 SHALL move DATA->WAIT; wr_data_req outside DATA SHALL be ignored, with fifo_rd_req=0.
REQ-010 WAIT->IDLE SHALL occur on burst_done, with burst_cnt incremented (wrapping at 2^16) on the same edge.
REQ-011 On WAIT->IDLE the address SHALL advance as follows: if burst_addr+burst_len > ADDR_TOP then burst_addr = ADDR_BASE, else burst_addr = burst_addr+burst_len; the sum SHALL be computed ADDR_WIDTH+1 bits wide.
REQ-012 addr_load SHALL set burst_addr=addr_in only in IDLE; it SHALL be ignored in other states, and in IDLE it SHALL take priority over a same-cycle burst start (the start is deferred one cycle).
REQ-013 underflow SHALL be set when wr_data_req=1 in DATA while fifo_rd_empty=1; the beat counter SHALL still decrement (the controller already consumed a beat); underflow SHALL clear only on rst.
REQ-014 Deasserting enable or flush after leaving IDLE SHALL NOT abort the burst in progress.
REQ-015 burst_done seen in IDLE, REQ or DATA SHALL be ignored.
REQ-016 busy SHALL be 1 in every state except IDLE.

Reset
REQ-017 On rst the block SHALL go to IDLE with burst_addr=ADDR_BASE, burst_len=0, beat counter=0, burst_cnt=0, underflow=0, burst_req=0, fifo_rd_req=0 and busy=0.
REQ-018 rst mid-burst SHALL abandon the burst immediately without popping the FIFO; recovering the controller is the integrator's responsibility.

Structure
REQ-019 The FSM state encoding and the BURST_LEN default SHALL live in the shared sdram package, reused by the read-side filler.
REQ-020 The address advance/wrap logic SHALL be one sub-module, sdram_addr_wrap (combinational, ADDR_WIDTH-parameterised).

Verification
REQ-021 Full burst: fifo_rd_num=8, enable=1 -> burst_req next cycle with addr 0 and len 8; after ack, 8 wr_data_req -> 8 pops in FIFO order; burst_done -> burst_cnt=1, burst_addr=8.
REQ-022 Flush partial: fifo_rd_num=3, flush=1 -> burst_len=3; exactly 3 pops; next address 3.
REQ-023 Wrap: ADDR_TOP=15, addr_load 12, full burst of 8 -> next burst_addr=0.
REQ-024 Underflow: fifo_rd_empty=1 during DATA with wr_data_req=1 -> underflow=1, fifo_rd_req=0, the FSM still reaches WAIT after 8 beats.
REQ-025 burst_ack held 0 for 5 cycles -> burst_req, burst_addr and burst_len stay stable; enable dropped during DATA -> the burst completes.
REQ-026 rst asserted in DATA after 4 beats -> all outputs take their reset values asynchronously; no further pops.
